matmul_stream_io: RTL and testbench
===================================

# matmul_stream_io

Streaming front-end for the matrix-multiply engine. Accepts two N×N operand matrices on a valid/ready input stream and writes them row-major into the engine's X and Y memories. Pulses the engine start, waits for done, then reads the Z memory back out as a valid/ready output stream with a last flag. It owns the write side of X/Y, the read side of Z, and the start/done handshake, so the engine needs no host logic.

## Interface
- DATA_WIDTH, 32, element width (signed two's complement, passed through unmodified)
- ADDR_WIDTH, 6, memory address width; MATRIX_SIZE*MATRIX_SIZE must be ≤ 2**ADDR_WIDTH
- MATRIX_SIZE, 8, N; each matrix is N*N elements
- clock  in  1  clock; all logic on rising edge
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  input element valid
- in_data  in  DATA_WIDTH  input element
- in_ready  out  1  block accepts in_data this cycle
- x_addr, y_addr  out  ADDR_WIDTH  X/Y memory write address
- x_din, y_din  out  DATA_WIDTH  X/Y write data
- x_wr_en, y_wr_en  out  1  X/Y write strobe (synchronous write)
- mm_start  out  1  engine start, one-cycle pulse
- mm_done  in  1  engine done level
- z_addr  out  ADDR_WIDTH  Z memory read address
- z_dout  in  DATA_WIDTH  Z read data, valid one cycle after z_addr
- out_valid  out  1  output element valid
- out_data  out  DATA_WIDTH  output element (registered)
- out_last  out  1  high with the final (N*N-1) element
- out_ready  in  1  downstream accepts
- busy  out  1  high in START, WAIT, DRAIN_RD, DRAIN_OUT

## Operation
- States: LOAD_X, LOAD_Y, START, WAIT, DRAIN_RD, DRAIN_OUT. One element counter `cnt` (ADDR_WIDTH bits, 0..N*N-1).
- LOAD_X: in_ready=1. On in_valid&in_ready: x_wr_en=1, x_addr=cnt, x_din=in_data (combinational). cnt increments. If cnt==N*N-1: cnt←0 and → LOAD_Y.
- LOAD_Y: same as LOAD_X but on y_*. If cnt==N*N-1: cnt←0 and → START.
- START: mm_start=1 for exactly this cycle. → WAIT.
- WAIT: the first WAIT cycle ignores mm_done, so a stale done from the previous job is not taken. From the second cycle on, mm_done==1 → DRAIN_RD with cnt=0.
- DRAIN_RD: z_addr=cnt. → DRAIN_OUT. At that edge out_data←z_dout and out_valid←1. z_addr is held for the sampling cycle.
- DRAIN_OUT: out_valid=1, out_last=(cnt==N*N-1). On out_ready:
  - out_valid←0.
  - If last: cnt←0 and → LOAD_X.
  - Otherwise: cnt+1 and → DRAIN_RD.
  - out_data is stable while out_valid & !out_ready.
- in_ready=0 outside LOAD_X/LOAD_Y; in_valid is ignored there. x/y_wr_en=0 outside their load state.
- Data is not interpreted; no arithmetic besides cnt increment. cnt never exceeds N*N-1; no wrap past the matrix.

## Timing
- Reset (async) values:
  - State LOAD_X, cnt=0, all address buses 0.
  - out_valid, out_data, out_last, mm_start, busy all 0.
  - x/y_wr_en=0, in_ready=1 after reset deasserts.
- Reset mid-operation from any state returns to LOAD_X. Partially loaded data is abandoned, and the next input element is written to X address 0. A pending output is dropped.
- Load throughput: 1 element/cycle. Write occurs on the edge where in_valid&in_ready.
- mm_start rises in the cycle after the final Y handshake.
- Minimum: mm_done sampled 2 cycles after the mm_start cycle.
- Drain throughput: 1 element per 2 cycles with out_ready tied high.
- out_valid first asserts 2 cycles after mm_done is accepted in WAIT.
- in_ready goes high the cycle after the final out handshake.
- out_valid never drops without a handshake; out_last only asserts with out_valid.
- Simultaneous events: mm_done outside WAIT is ignored; out_ready without out_valid has no effect.

## Test plan
- Reset: assert reset mid-cycle with no clock → all outputs at reset values immediately; after release in_ready=1 and busy=0.
- Load with bubbles (N=2): send 1,2,3,4 then 5,6,7,8 with in_valid toggling every other cycle → X[0..3]=1..4 and Y[0..3]=5..8. Exactly 8 write strobes; mm_start pulses once for one cycle.
- Stale done: hold mm_done=1 through START, drop it for 5 cycles, then raise it → DRAIN_RD entered only after the re-raise, not in the first WAIT cycle.
- Drain with backpressure: Z memory model = {19,22,43,50}, out_ready random 50% → out stream 19,22,43,50. out_data holds while stalled; out_last only on 50; then state LOAD_X.
- Reset mid-load: after 3 X elements, pulse reset, then load a full job → X[0] holds the first post-reset element and the output is correct.
- Back-to-back jobs: two consecutive full jobs with different data → the second output matches the second job's data. No extra mm_start; busy low between jobs.

Source files
------------

// File: rtl/matmul_stream_io.sv
// Streaming host front-end for the matrix-multiply engine: loads X and Y from an
// input stream, kicks the engine, then streams Z back out with a last flag.
module matmul_stream_io #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int MATRIX_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic [ADDR_WIDTH-1:0] x_addr_o,
  output logic [ADDR_WIDTH-1:0] y_addr_o,
  output logic [DATA_WIDTH-1:0] x_din_o,
  output logic [DATA_WIDTH-1:0] y_din_o,
  output logic                  x_wr_en_o,
  output logic                  y_wr_en_o,
  output logic                  mm_start_o,
  input  logic                  mm_done_i,
  output logic [ADDR_WIDTH-1:0] z_addr_o,
  input  logic [DATA_WIDTH-1:0] z_dout_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  busy_o
);

  localparam int NUM_ELEM = MATRIX_SIZE * MATRIX_SIZE;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_ELEM - 1);

  typedef enum logic [2:0] {
    S_LOAD_X,
    S_LOAD_Y,
    S_START,
    S_WAIT,
    S_DRAIN_RD,
    S_DRAIN_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wait_first_q, wait_first_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  cnt_last;
  logic [ADDR_WIDTH-1:0] cnt_inc;

  assign cnt_last = (cnt_q == LAST_IDX);
  assign cnt_inc  = cnt_q + ADDR_WIDTH'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_LOAD_X;
      cnt_q        <= '0;
      wait_first_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wait_first_q <= wait_first_d;
      out_data_q   <= out_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wait_first_d = wait_first_q;
    out_data_d   = out_data_q;
    in_ready_o   = 1'b0;
    x_wr_en_o    = 1'b0;
    y_wr_en_o    = 1'b0;
    mm_start_o   = 1'b0;
    out_valid_o  = 1'b0;
    out_last_o   = 1'b0;
    busy_o       = 1'b0;
    z_addr_o     = cnt_q;

    case (state_q)
      S_LOAD_X: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          x_wr_en_o = 1'b1;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = S_LOAD_Y;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_LOAD_Y: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          y_wr_en_o = 1'b1;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_START: begin
        busy_o       = 1'b1;
        mm_start_o   = 1'b1;
        wait_first_d = 1'b1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // A done level left over from the previous job is not trusted on the first cycle.
        busy_o       = 1'b1;
        wait_first_d = 1'b0;
        if (!wait_first_q && mm_done_i) begin
          cnt_d   = '0;
          state_d = S_DRAIN_RD;
        end
      end
      S_DRAIN_RD: begin
        busy_o     = 1'b1;
        out_data_d = z_dout_i;
        state_d    = S_DRAIN_OUT;
      end
      S_DRAIN_OUT: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        out_last_o  = cnt_last;
        if (out_ready_i) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = S_LOAD_X;
          end else begin
            // Present the next address on the handshake cycle so the synchronous
            // Z read has landed by the end of the following DRAIN_RD cycle.
            cnt_d    = cnt_inc;
            z_addr_o = cnt_inc;
            state_d  = S_DRAIN_RD;
          end
        end
      end
      default: state_d = S_LOAD_X;
    endcase
  end

  assign x_addr_o   = cnt_q;
  assign y_addr_o   = cnt_q;
  assign x_din_o    = in_data_i;
  assign y_din_o    = in_data_i;
  assign out_data_o = out_data_q;

endmodule

// File: tb/tb_matmul_stream_io.sv
// Bench for matmul_stream_io: X/Y/Z memories plus a behavioural engine around the
// DUT, random operands, expected Z from plain matrix arithmetic on the stimulus.
module tb_matmul_stream_io;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 2;
  localparam int NN = N * N;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] x_addr, y_addr, z_addr;
  logic [DW-1:0] x_din, y_din;
  logic          x_wr_en, y_wr_en;
  logic          mm_start;
  logic          mm_done;
  logic [DW-1:0] z_dout = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int strobes = 0;
  int start_cnt = 0;

  logic [DW-1:0] xmem [16];
  logic [DW-1:0] ymem [16];
  logic [DW-1:0] zmem [16];
  logic [DW-1:0] xv [NN];
  logic [DW-1:0] yv [NN];

  matmul_stream_io #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATRIX_SIZE(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .x_addr_o    (x_addr),
    .y_addr_o    (y_addr),
    .x_din_o     (x_din),
    .y_din_o     (y_din),
    .x_wr_en_o   (x_wr_en),
    .y_wr_en_o   (y_wr_en),
    .mm_start_o  (mm_start),
    .mm_done_i   (mm_done),
    .z_addr_o    (z_addr),
    .z_dout_i    (z_dout),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] eng_dot(input int idx);
    logic [DW-1:0] acc = '0;
    for (int k = 0; k < N; k++) acc += xmem[(idx / N) * N + k] * ymem[k * N + (idx % N)];
    return acc;
  endfunction

  // Memories and engine stand-in: the engine product is computed when start pulses.
  always @(posedge clock) begin
    if (x_wr_en) xmem[x_addr] <= x_din;
    if (y_wr_en) ymem[y_addr] <= y_din;
    if (x_wr_en || y_wr_en) strobes <= strobes + 1;
    if (mm_start) begin
      start_cnt <= start_cnt + 1;
      for (int i = 0; i < NN; i++) zmem[i] <= eng_dot(i);
    end
    z_dout <= zmem[z_addr];
  end

  function automatic logic [DW-1:0] zref(input int idx);
    logic [DW-1:0] acc = '0;
    for (int k = 0; k < N; k++) acc += xv[(idx / N) * N + k] * yv[k * N + (idx % N)];
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NN; i++) begin
      xv[i] = $urandom;
      yv[i] = $urandom;
    end
  endtask

  task automatic load(input bit bubbles);
    for (int i = 0; i < 2 * NN; i++) begin
      if (bubbles && i > 0) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        tick();
      end
      in_valid = 1'b1;
      in_data  = (i < NN) ? xv[i] : yv[i - NN];
      chk("in_ready_load", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    chk("mm_start_after_y", 32'(mm_start), 32'd1);
    chk("busy_start", 32'(busy), 32'd1);
    chk("in_ready_start", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_done(input bit stale);
    if (stale) begin
      tick();
      chk("mm_start_one_cycle", 32'(mm_start), 32'd0);
      tick();
      mm_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
        chk("stale_done_ignored", 32'(out_valid), 32'd0);
        tick();
      end
    end else begin
      mm_done = 1'b0;
      tick();
      chk("mm_start_one_cycle", 32'(mm_start), 32'd0);
      tick();
    end
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    chk("drain_rd_valid", 32'(out_valid), 32'd0);
    chk("drain_rd_busy", 32'(busy), 32'd1);
  endtask

  task automatic drain(input bit rnd);
    int got = 0;
    int cyc = 0;
    while (got < NN && cyc < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        chk("out_data", out_data, zref(got));
        chk("out_last", 32'(out_last), 32'(got == NN - 1));
        if (out_ready) begin
          $display("out[%0d] = %0h last=%0b", got, out_data, out_last);
          got++;
        end
      end else begin
        chk("out_last_idle", 32'(out_last), 32'd0);
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(got), 32'(NN));
    if (!rnd) chk("drain_cycles", 32'(cyc), 32'(2 * NN));
    chk("in_ready_after_drain", 32'(in_ready), 32'd1);
    chk("busy_after_drain", 32'(busy), 32'd0);
  endtask

  initial begin
    int sc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    mm_done   = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_mm_start", 32'(mm_start), 32'd0);
    chk("rst_x_addr", 32'(x_addr), 32'd0);
    chk("rst_y_addr", 32'(y_addr), 32'd0);
    chk("rst_z_addr", 32'(z_addr), 32'd0);
    chk("rst_x_wr_en", 32'(x_wr_en), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Job 1: bubbled load, stale done held through START, random backpressure.
    for (int i = 0; i < NN; i++) begin
      xv[i] = 32'(i + 1);
      yv[i] = 32'(i + 5);
    end
    mm_done = 1'b1;
    load(1'b1);
    chk("write_strobes", 32'(strobes), 32'd8);
    for (int i = 0; i < NN; i++) begin
      chk("xmem", xmem[i], xv[i]);
      chk("ymem", ymem[i], yv[i]);
    end
    wait_done(1'b1);
    drain(1'b1);
    chk("start_count_job1", 32'(start_cnt), 32'd1);

    // Job 2: reset after three X elements, then a full job.
    randomize_ops();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("midload_rst_x_addr", 32'(x_addr), 32'd0);
    chk("midload_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midload_rst_busy", 32'(busy), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    load(1'b0);
    chk("xmem0_after_rst", xmem[0], xv[0]);
    wait_done(1'b0);
    drain(1'b0);

    // Job 3: reset while an output is pending drops it.
    randomize_ops();
    load(1'b0);
    wait_done(1'b0);
    tick();
    chk("pending_out_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("middrain_rst_valid", 32'(out_valid), 32'd0);
    chk("middrain_rst_data", out_data, 32'd0);
    chk("middrain_rst_busy", 32'(busy), 32'd0);
    #1;
    reset = 1'b0;
    tick();

    // Jobs 4 and 5 back to back, one start pulse each.
    sc = start_cnt;
    for (int j = 0; j < 2; j++) begin
      randomize_ops();
      load(1'b0);
      wait_done(1'b0);
      drain(j == 1);
      chk("start_count_b2b", 32'(start_cnt), 32'(sc + j + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
